// File: rtl/project_types.sv
// Shared EX-stage types: reset polarity, operand word, divider state encoding.
package project_types;

  typedef logic reset_status_t;
  localparam reset_status_t RST_ENABLE = 1'b1;

  typedef logic [31:0] reg_data_t;

  localparam int DIV_CYCLES = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIVZERO = 2'd1,
    ON      = 2'd2,
    END     = 2'd3
  } div_state_t;

endpackage

// File: rtl/ex_div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; returns {remainder, quotient}
// after 32 iterations, holding the result until the requester drops start_i.
module ex_div
  import project_types::*;
(
  input  logic          clk,
  input  reset_status_t rst,
  input  logic          start_i,
  input  logic          annul_i,
  input  logic          signed_i,
  input  reg_data_t     dividend_i,
  input  reg_data_t     divisor_i,
  output logic [63:0]   result_o,
  output logic          ready_o
);

  localparam logic [5:0] CNT_LAST = 6'(DIV_CYCLES);

  div_state_t  state, state_nxt;
  logic [5:0]  cnt;
  logic [63:0] work;
  reg_data_t   divisor_q;
  logic        sign_q, sign_r;
  logic [32:0] trial;

  function automatic reg_data_t magnitude(input reg_data_t x, input logic is_signed);
    logic signed [31:0] sx;
    sx = signed'(x);
    return (is_signed && sx < 0) ? reg_data_t'(-sx) : x;
  endfunction

  function automatic reg_data_t apply_sign(input reg_data_t x, input logic neg);
    logic signed [31:0] sx;
    sx = signed'(x);
    return neg ? reg_data_t'(-sx) : x;
  endfunction

  // Trial subtract on the shifted partial remainder; bit 32 is the borrow because
  // the remainder is always below 2*divisor, so the difference fits in 33 bits.
  assign trial = work[63:31] - {1'b0, divisor_q};

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) state <= IDLE;
    else                   state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (annul_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_i) state_nxt = (divisor_i == '0) ? DIVZERO : ON;
        DIVZERO: state_nxt = END;
        ON:      if (cnt == CNT_LAST) state_nxt = END;
        END:     if (!start_i) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      cnt       <= '0;
      work      <= '0;
      divisor_q <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      result_o  <= '0;
      ready_o   <= 1'b0;
    end else if (annul_i) begin
      cnt      <= '0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          result_o <= '0;
          ready_o  <= 1'b0;
          if (start_i && divisor_i != '0) begin
            cnt       <= '0;
            work      <= {32'b0, magnitude(dividend_i, signed_i)};
            divisor_q <= magnitude(divisor_i, signed_i);
            sign_q    <= signed_i & (dividend_i[31] ^ divisor_i[31]);
            sign_r    <= signed_i & dividend_i[31];
          end
        end
        DIVZERO: begin
          result_o <= '0;
          ready_o  <= 1'b1;
        end
        ON: begin
          if (cnt != CNT_LAST) begin
            work <= trial[32] ? {work[62:0], 1'b0} : {trial[31:0], work[30:0], 1'b1};
            cnt  <= cnt + 6'd1;
          end else begin
            result_o <= {apply_sign(work[63:32], sign_r), apply_sign(work[31:0], sign_q)};
            ready_o  <= 1'b1;
          end
        end
        END: begin
          if (!start_i) begin
            result_o <= '0;
            ready_o  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
